// File: rtl/vrf_bank_arbiter_if.sv
// rtl/vrf_bank_arbiter_if.sv - requester and VRF bank bundle of the lane bank arbiter
interface vrf_bank_arbiter_if #(
    parameter int NrBanks   = 8,
    parameter int NrReq     = 4,
    parameter int AddrWidth = 16,
    parameter int DataWidth = 64,
    parameter int OpqWidth  = 3
);
    localparam int StrbWidth = DataWidth / 8;

    logic [NrReq-1:0]             req_valid_i;
    logic [NrReq-1:0]             req_ready_o;
    logic [NrReq*AddrWidth-1:0]   req_addr_i;
    logic [NrReq-1:0]             req_wen_i;
    logic [NrReq*DataWidth-1:0]   req_wdata_i;
    logic [NrReq*StrbWidth-1:0]   req_be_i;
    logic [NrReq*OpqWidth-1:0]    req_opq_i;

    logic [NrBanks-1:0]           vrf_req_o;
    logic [NrBanks*AddrWidth-1:0] vrf_addr_o;
    logic [NrBanks-1:0]           vrf_wen_o;
    logic [NrBanks*DataWidth-1:0] vrf_wdata_o;
    logic [NrBanks*StrbWidth-1:0] vrf_be_o;
    logic [NrBanks*OpqWidth-1:0]  vrf_tgt_opqueue_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_wen_i, req_wdata_i, req_be_i, req_opq_i,
        output req_ready_o, vrf_req_o, vrf_addr_o, vrf_wen_o, vrf_wdata_o, vrf_be_o,
               vrf_tgt_opqueue_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_wen_i, req_wdata_i, req_be_i, req_opq_i,
        input  req_ready_o, vrf_req_o, vrf_addr_o, vrf_wen_o, vrf_wdata_o, vrf_be_o,
               vrf_tgt_opqueue_o
    );
endinterface

// File: rtl/vrf_bank_arbiter.sv
// rtl/vrf_bank_arbiter.sv - per-bank VRF arbiter: starved reads, then writes, then round-robin reads
module vrf_bank_arbiter #(
    parameter int NrBanks     = 8,
    parameter int NrReq       = 4,
    parameter int AddrWidth   = 16,
    parameter int DataWidth   = 64,
    parameter int OpqWidth    = 3,
    parameter int StarveLimit = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        perf_clr_i,
    output logic [15:0] conflict_cnt_o,
    vrf_bank_arbiter_if.slave bus
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int BankBits  = $clog2(NrBanks);
    localparam int ReqIdx    = $clog2(NrReq);

    logic [BankBits-1:0] req_bank  [NrReq];
    logic [NrReq-1:0]    starved;
    logic [NrBanks-1:0]  gnt_valid;
    logic [ReqIdx-1:0]   gnt_idx   [NrBanks];
    logic [ReqIdx-1:0]   rr_ptr_q  [NrBanks];
    logic [7:0]          wait_cnt_q[NrReq];
    logic [NrReq-1:0]    ready;
    logic [15:0]         conflict_q;

    always_comb begin
        for (int r = 0; r < NrReq; r++) begin
            req_bank[r] = bus.req_addr_i[r*AddrWidth +: BankBits];
            starved[r]  = bus.req_valid_i[r] && !bus.req_wen_i[r] &&
                          (wait_cnt_q[r] == 8'(StarveLimit));
        end
    end

    // Three passes per bank; the first hit in priority order sticks.
    always_comb begin : arb
        int idx;
        idx = 0;
        for (int b = 0; b < NrBanks; b++) begin
            gnt_valid[b] = 1'b0;
            gnt_idx[b]   = '0;
            for (int r = 0; r < NrReq; r++) begin
                if (!gnt_valid[b] && starved[r] && (req_bank[r] == BankBits'(b))) begin
                    gnt_valid[b] = 1'b1;
                    gnt_idx[b]   = ReqIdx'(r);
                end
            end
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < NrReq; k++) begin
                    idx = (int'(rr_ptr_q[b]) + k) % NrReq;
                    if (!gnt_valid[b] && bus.req_valid_i[idx] &&
                        (req_bank[idx] == BankBits'(b)) &&
                        (bus.req_wen_i[idx] == (pass == 0))) begin
                        gnt_valid[b] = 1'b1;
                        gnt_idx[b]   = ReqIdx'(idx);
                    end
                end
            end
        end
        if (rst_i) begin
            gnt_valid = '0;
        end
    end

    always_comb begin
        for (int r = 0; r < NrReq; r++) begin
            ready[r] = bus.req_valid_i[r] && gnt_valid[req_bank[r]] &&
                       (gnt_idx[req_bank[r]] == ReqIdx'(r));
        end
    end

    assign bus.req_ready_o = ready;
    assign conflict_cnt_o  = conflict_q;

    always_comb begin : payload
        int g;
        g = 0;
        bus.vrf_req_o         = '0;
        bus.vrf_addr_o        = '0;
        bus.vrf_wen_o         = '0;
        bus.vrf_wdata_o       = '0;
        bus.vrf_be_o          = '0;
        bus.vrf_tgt_opqueue_o = '0;
        for (int b = 0; b < NrBanks; b++) begin
            if (gnt_valid[b]) begin
                g = int'(gnt_idx[b]);
                bus.vrf_req_o[b] = 1'b1;
                bus.vrf_wen_o[b] = bus.req_wen_i[g];
                bus.vrf_addr_o[b*AddrWidth +: AddrWidth] =
                    bus.req_addr_i[g*AddrWidth +: AddrWidth] >> BankBits;
                bus.vrf_wdata_o[b*DataWidth +: DataWidth] = bus.req_wdata_i[g*DataWidth +: DataWidth];
                bus.vrf_be_o[b*StrbWidth +: StrbWidth]    = bus.req_be_i[g*StrbWidth +: StrbWidth];
                bus.vrf_tgt_opqueue_o[b*OpqWidth +: OpqWidth] = bus.req_opq_i[g*OpqWidth +: OpqWidth];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NrBanks; b++) rr_ptr_q[b] <= '0;
            for (int r = 0; r < NrReq; r++)   wait_cnt_q[r] <= '0;
            conflict_q <= '0;
        end else begin
            for (int b = 0; b < NrBanks; b++) begin
                if (gnt_valid[b]) begin
                    rr_ptr_q[b] <= (gnt_idx[b] == ReqIdx'(NrReq - 1)) ? '0
                                                                      : gnt_idx[b] + ReqIdx'(1);
                end
            end
            for (int r = 0; r < NrReq; r++) begin
                if (!bus.req_valid_i[r] || ready[r]) begin
                    wait_cnt_q[r] <= '0;
                end else if (wait_cnt_q[r] < 8'(StarveLimit)) begin
                    wait_cnt_q[r] <= wait_cnt_q[r] + 8'd1;
                end
            end
            if (perf_clr_i) begin
                conflict_q <= '0;
            end else if ((|(bus.req_valid_i & ~ready)) && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// tb/tb_vrf_bank_arbiter.sv - scoreboard bench for vrf_bank_arbiter
module tb_vrf_bank_arbiter;
    localparam int NrBanks = 8;
    localparam int NrReq   = 4;
    localparam int AW      = 16;
    localparam int DW      = 64;
    localparam int OW      = 3;
    localparam int SW      = DW / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        perf_clr = 1'b0;
    logic [15:0] conflict;

    vrf_bank_arbiter_if #(.NrBanks(NrBanks), .NrReq(NrReq), .AddrWidth(AW),
                          .DataWidth(DW), .OpqWidth(OW)) bus ();

    vrf_bank_arbiter #(.NrBanks(NrBanks), .NrReq(NrReq), .AddrWidth(AW), .DataWidth(DW),
                       .OpqWidth(OW), .StarveLimit(7)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .perf_clr_i    (perf_clr),
        .conflict_cnt_o(conflict),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NrReq-1:0]   ready;
        logic [NrBanks-1:0] vreq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_conflict = 0;

    task automatic set_req(input int r, input logic v, input logic wen, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [SW-1:0] be, input logic [OW-1:0] opq);
        bus.req_valid_i[r]          = v;
        bus.req_wen_i[r]            = wen;
        bus.req_addr_i[r*AW +: AW]  = addr;
        bus.req_wdata_i[r*DW +: DW] = wd;
        bus.req_be_i[r*SW +: SW]    = be;
        bus.req_opq_i[r*OW +: OW]   = opq;
    endtask

    task automatic clear_all();
        bus.req_valid_i = '0;
        bus.req_wen_i   = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_be_i    = '0;
        bus.req_opq_i   = '0;
    endtask

    task automatic push_exp(input logic [NrReq-1:0] rdy, input logic [NrBanks-1:0] vreq);
        exp_t e;
        e.ready = rdy;
        e.vreq  = vreq;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 1'b0, 16'h0010, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 4'b0) begin
            failures++; $display("FAIL reset_ready got=%b want=0000", bus.req_ready_o);
        end
        checks++;
        if (bus.vrf_req_o !== 8'b0) begin
            failures++; $display("FAIL reset_vrf_req got=%b want=00000000", bus.vrf_req_o);
        end
        checks++;
        if (conflict !== 16'd0) begin
            failures++; $display("FAIL reset_conflict got=%0d want=0", conflict);
        end
        clear_all();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_parallel_banks();
        exp_t e;
        set_req(0, 1'b1, 1'b0, 16'h0010, '0, '0, 3'd5);
        set_req(1, 1'b1, 1'b0, 16'h0011, '0, '0, 3'd2);
        push_exp(4'b0011, 8'b0000_0011);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.req_ready_o !== e.ready) begin
            failures++; $display("FAIL par_ready got=%b want=%b", bus.req_ready_o, e.ready);
        end
        checks++;
        if (bus.vrf_req_o !== e.vreq) begin
            failures++; $display("FAIL par_vrf_req got=%b want=%b", bus.vrf_req_o, e.vreq);
        end
        checks++;
        if (bus.vrf_addr_o[0 +: AW] !== 16'd2) begin
            failures++; $display("FAIL par_addr0 got=%0h want=2", bus.vrf_addr_o[0 +: AW]);
        end
        checks++;
        if (bus.vrf_addr_o[AW +: AW] !== 16'd2) begin
            failures++; $display("FAIL par_addr1 got=%0h want=2", bus.vrf_addr_o[AW +: AW]);
        end
        checks++;
        if (bus.vrf_tgt_opqueue_o[0 +: OW] !== 3'd5) begin
            failures++; $display("FAIL par_opq0 got=%0d want=5", bus.vrf_tgt_opqueue_o[0 +: OW]);
        end
        checks++;
        if (bus.vrf_wen_o !== 8'b0) begin
            failures++; $display("FAIL par_wen got=%b want=0", bus.vrf_wen_o);
        end
        @(posedge clk); #1;
        clear_all();
        checks++;
        if (conflict !== 16'(exp_conflict)) begin
            failures++; $display("FAIL par_conflict got=%0d want=%0d", conflict, exp_conflict);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [NrReq-1:0] seq [4];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
        set_req(0, 1'b1, 1'b0, 16'h0003, '0, '0, '0);
        set_req(1, 1'b1, 1'b0, 16'h000B, '0, '0, '0);
        set_req(2, 1'b1, 1'b0, 16'h0013, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            push_exp(seq[i], 8'h08);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.req_ready_o !== e.ready || bus.vrf_req_o !== e.vreq) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=%b/%b want=%b/%b", i, bus.req_ready_o,
                         bus.vrf_req_o, e.ready, e.vreq);
            end
            @(posedge clk); #1;
            exp_conflict++;
            checks++;
            if (conflict !== 16'(exp_conflict)) begin
                failures++; $display("FAIL rr_conflict[%0d] got=%0d want=%0d", i, conflict, exp_conflict);
            end
        end
        clear_all();
    endtask

    task automatic test_write_priority();
        exp_t e;
        set_req(0, 1'b1, 1'b0, 16'h0002, '0, '0, '0);
        set_req(3, 1'b1, 1'b1, 16'h000A, 64'hDEAD, 8'hFF, '0);
        push_exp(4'b1000, 8'h04);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.req_ready_o !== e.ready || bus.vrf_req_o !== e.vreq) begin
            failures++;
            $display("FAIL wr_grant got=%b/%b want=%b/%b", bus.req_ready_o, bus.vrf_req_o, e.ready, e.vreq);
        end
        checks++;
        if (bus.vrf_wen_o[2] !== 1'b1 || bus.vrf_wdata_o[2*DW +: DW] !== 64'hDEAD ||
            bus.vrf_be_o[2*SW +: SW] !== 8'hFF || bus.vrf_addr_o[2*AW +: AW] !== 16'd1) begin
            failures++;
            $display("FAIL wr_payload got=wen%b data%0h be%0h row%0h want=wen1 dataDEAD beFF row1",
                     bus.vrf_wen_o[2], bus.vrf_wdata_o[2*DW +: DW], bus.vrf_be_o[2*SW +: SW],
                     bus.vrf_addr_o[2*AW +: AW]);
        end
        @(posedge clk); #1;
        exp_conflict++;
        set_req(3, 1'b0, 1'b0, '0, '0, '0, '0);
        push_exp(4'b0001, 8'h04);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.req_ready_o !== e.ready || bus.vrf_wen_o[2] !== 1'b0) begin
            failures++;
            $display("FAIL wr_then_rd got=%b wen%b want=%b wen0", bus.req_ready_o, bus.vrf_wen_o[2], e.ready);
        end
        @(posedge clk); #1;
        clear_all();
        checks++;
        if (conflict !== 16'(exp_conflict)) begin
            failures++; $display("FAIL wr_conflict got=%0d want=%0d", conflict, exp_conflict);
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        logic r1_gnt;
        logic [NrReq-1:0] seq [10];
        seq = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001,
                4'b0010, 4'b1000, 4'b0001};
        set_req(0, 1'b1, 1'b1, 16'h0005, 64'h1, 8'hFF, '0);
        set_req(3, 1'b1, 1'b1, 16'h000D, 64'h2, 8'hFF, '0);
        set_req(1, 1'b1, 1'b0, 16'h0015, '0, '0, 3'd1);
        for (int i = 0; i < 10; i++) begin
            push_exp(seq[i], 8'h20);
            @(negedge clk);
            e = exp_q.pop_front();
            r1_gnt = bus.req_ready_o[1];
            checks++;
            if (bus.req_ready_o !== e.ready || bus.vrf_req_o !== e.vreq) begin
                failures++;
                $display("FAIL starve_grant[%0d] got=%b/%b want=%b/%b", i, bus.req_ready_o,
                         bus.vrf_req_o, e.ready, e.vreq);
            end
            @(posedge clk); #1;
            exp_conflict++;
            if (r1_gnt) set_req(1, 1'b0, 1'b0, '0, '0, '0, '0);
        end
        clear_all();
        checks++;
        if (conflict !== 16'(exp_conflict)) begin
            failures++; $display("FAIL starve_conflict got=%0d want=%0d", conflict, exp_conflict);
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        set_req(0, 1'b1, 1'b0, 16'h0006, '0, '0, '0);
        set_req(1, 1'b1, 1'b0, 16'h000E, '0, '0, '0);
        set_req(2, 1'b1, 1'b0, 16'h0016, '0, '0, '0);
        push_exp(4'b0001, 8'h40);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.req_ready_o !== e.ready) begin
            failures++; $display("FAIL mid_pre got=%b want=%b", bus.req_ready_o, e.ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0 || bus.vrf_req_o !== 8'b0) begin
            failures++;
            $display("FAIL mid_rst_outputs got=%b/%b want=0000/00000000", bus.req_ready_o, bus.vrf_req_o);
        end
        checks++;
        if (conflict !== 16'd0) begin
            failures++; $display("FAIL mid_rst_conflict got=%0d want=0", conflict);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_conflict = 0;
        push_exp(4'b0001, 8'h40);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.req_ready_o !== e.ready || bus.vrf_req_o !== e.vreq) begin
            failures++;
            $display("FAIL mid_restart got=%b/%b want=%b/%b", bus.req_ready_o, bus.vrf_req_o, e.ready, e.vreq);
        end
        @(posedge clk); #1;
        exp_conflict++;
        checks++;
        if (conflict !== 16'(exp_conflict)) begin
            failures++; $display("FAIL mid_conflict got=%0d want=%0d", conflict, exp_conflict);
        end
        clear_all();
    endtask

    task automatic test_conflict_saturation();
        set_req(0, 1'b1, 1'b0, 16'h0007, '0, '0, '0);
        set_req(1, 1'b1, 1'b0, 16'h000F, '0, '0, '0);
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (conflict !== 16'hFFFF) begin
            failures++; $display("FAIL sat_conflict got=%0h want=ffff", conflict);
        end
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        checks++;
        if (conflict !== 16'd0) begin
            failures++; $display("FAIL sat_clear got=%0d want=0", conflict);
        end
        @(posedge clk); #1;
        checks++;
        if (conflict !== 16'd1) begin
            failures++; $display("FAIL sat_after_clear got=%0d want=1", conflict);
        end
        clear_all();
    endtask

    initial begin
        clear_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_parallel_banks();
        test_round_robin();
        test_write_priority();
        test_starvation();
        test_reset_midstream();
        test_conflict_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
